// File: rtl/apb_mac_cfg_slave.sv
// APB configuration slave for one MAC: control/status/interrupt registers,
// a TX word FIFO toward the MAC core and a clear-on-read RX frame counter.
module apb_mac_cfg_slave #(
    parameter int WAIT_STATES = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [7:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        rx_event,
    output logic        mac_en,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [5:0] A_CTRL     = 6'h00;
    localparam logic [5:0] A_STATUS   = 6'h01;
    localparam logic [5:0] A_INT_EN   = 6'h02;
    localparam logic [5:0] A_INT_STAT = 6'h03;
    localparam logic [5:0] A_TX_DATA  = 6'h04;
    localparam logic [5:0] A_RX_CNT   = 6'h05;

    logic [2:0]    wcnt;
    logic          abort;
    logic [5:0]    addr;
    logic          wr_en;
    logic          rd_en;
    logic [2:0]    int_en;
    logic [2:0]    int_stat;
    logic [2:0]    int_set;
    logic [2:0]    int_clr;
    logic [15:0]   rx_cnt;
    logic          rx_rd;
    logic          rx_wrap;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic [4:0]    count5;
    logic          full;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          unused_addr_bits;

    assign addr             = paddr[7:2];
    assign unused_addr_bits = ^paddr[1:0];

    // abort holds off pready after a reset that lands inside an access
    // phase, until the bus goes back through a non-access cycle.
    assign pready = psel & penable & ~abort
                  & (wcnt == 3'(WAIT_STATES));
    assign wr_en  = pready & pwrite;
    assign rd_en  = pready & ~pwrite;

    always_ff @(posedge pclk) begin
        if (preset) begin
            wcnt  <= '0;
            abort <= 1'b1;
        end else begin
            if (!(psel && penable))
                abort <= 1'b0;
            if (!psel || pready || abort)
                wcnt <= '0;
            else if (penable)
                wcnt <= wcnt + 3'd1;
        end
    end

    assign full     = (count == CW'(FIFO_DEPTH));
    assign tx_valid = (count != '0);
    assign tx_data  = mem[rptr];
    assign count5   = 5'(count);
    assign push_req = wr_en & (addr == A_TX_DATA);
    assign push     = push_req & ~full;
    assign pop      = tx_valid & tx_ready;

    always_ff @(posedge pclk) begin
        if (preset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (push)
            mem[wptr] <= pwdata;
    end

    assign rx_rd   = rd_en & (addr == A_RX_CNT);
    assign rx_wrap = rx_event & ~rx_rd & (rx_cnt == 16'hFFFF);

    always_ff @(posedge pclk) begin
        if (preset)
            rx_cnt <= '0;
        else if (rx_rd)
            rx_cnt <= {15'd0, rx_event};
        else if (rx_event)
            rx_cnt <= rx_cnt + 16'd1;
    end

    assign int_set = {push_req & full,
                      rx_wrap,
                      pop & ~push & (count == CW'(1))};
    assign int_clr = (wr_en && addr == A_INT_STAT) ? pwdata[2:0] : 3'd0;

    always_ff @(posedge pclk) begin
        if (preset) begin
            mac_en   <= 1'b0;
            int_en   <= '0;
            int_stat <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_en && addr == A_CTRL)
                mac_en <= pwdata[0];
            if (wr_en && addr == A_INT_EN)
                int_en <= pwdata[2:0];
            // set is OR-ed in last so an event beats a same-cycle clear
            int_stat <= (int_stat & ~int_clr) | int_set;
            irq      <= |(int_stat & int_en);
        end
    end

    always_comb begin
        prdata = '0;
        if (psel) begin
            case (addr)
                A_CTRL:     prdata = {31'd0, mac_en};
                A_STATUS:   prdata = {25'd0, ~tx_valid, full, count5};
                A_INT_EN:   prdata = {29'd0, int_en};
                A_INT_STAT: prdata = {29'd0, int_stat};
                A_RX_CNT:   prdata = {16'd0, rx_cnt};
                default:    prdata = '0;
            endcase
        end
    end

endmodule

// File: doc/apb_mac_cfg_slave.md
# apb_mac_cfg_slave

APB slave that terminates one MAC peripheral-select line of the APB subsystem bridge (for example the `psel_mac0` / `prdata_mac0` / `pready_mac0` port group). It holds the MAC control, status and interrupt registers. It buffers transmit words in a small FIFO that the MAC core drains over a valid/ready handshake. It counts receive events and inserts a programmable number of APB wait states through `pready`.

## Interface

Parameters:
- `WAIT_STATES`, default 1: number of `pready`-low cycles in each access phase. Legal range 0..7.
- `FIFO_DEPTH`, default 4: number of TX FIFO entries. Must be a power of 2, range 2..16.

Ports:
- `pclk` in 1: the single clock for all logic.
- `preset` in 1: synchronous, active-high reset, sampled on the rising edge of `pclk`.
- `psel` in 1: APB select from the bridge.
- `penable` in 1: APB enable.
- `pwrite` in 1: 1 = write, 0 = read.
- `paddr` in 8: byte address. Decode uses `paddr[7:2]`; `paddr[1:0]` is ignored.
- `pwdata` in 32: write data.
- `prdata` out 32: read data.
- `pready` out 1: transfer complete.
- `tx_data` out 32: head entry of the TX FIFO.
- `tx_valid` out 1: TX FIFO is not empty.
- `tx_ready` in 1: MAC core accepts the head word.
- `rx_event` in 1: single-cycle pulse, one per received frame.
- `mac_en` out 1: CTRL[0].
- `irq` out 1: registered interrupt request.

## Operation

Register map (`paddr[7:2]`). Unmapped addresses read 0 and ignore writes.
- 0x00 CTRL, RW. Bit 0 is `mac_en`; bits 31:1 read 0.
- 0x04 STATUS, RO. Bits [4:0] = FIFO count (0..`FIFO_DEPTH`), bit 5 = full, bit 6 = empty.
- 0x08 INT_EN, RW. Bits [2:0]; other bits read 0.
- 0x0C INT_STAT, W1C. Each bit is cleared by writing 1 to it.
  - Bit 0: TX FIFO became empty (set on a pop that leaves count = 0).
  - Bit 1: RX_CNT wrapped.
  - Bit 2: TX push dropped because the FIFO was full.
  - If a set event and a W1C clear hit the same bit in the same cycle, set wins.
- 0x10 TX_DATA, WO (reads 0). A completed write pushes `pwdata`.
  - The push is dropped if the FIFO is full, judged on the count at the start of the cycle, even if a pop happens in the same cycle.
- 0x14 RX_CNT, RO, clear-on-read, bits [15:0].
  - Increments on each `rx_event`. Wraps 0xFFFF→0 and sets INT_STAT[1].
  - A completed read returns the current value and clears the counter. If `rx_event` arrives in that same cycle, the counter becomes 1.

APB protocol:
- Setup phase: `psel`=1, `penable`=0. Access phase: `psel`=1, `penable`=1.
- Wait counter `wcnt` (3 bits) increments each access-phase cycle while `pready`=0. It clears when the transfer completes, when `psel`=0, and on reset.
- `pready` = `psel` & `penable` & (`wcnt` == `WAIT_STATES`). It is combinational from the registered `wcnt`.
- Writes and the RX_CNT read-clear take effect only on the edge where `pready`=1.
- `prdata` is driven from the decoded register while `psel`=1 and is 0 otherwise. It is only guaranteed meaningful while `pready`=1.

TX FIFO:
- Circular buffer with read/write pointers of width log2(`FIFO_DEPTH`) and a separate count.
- Pop occurs on `tx_valid` & `tx_ready`.
- Push and pop in the same cycle when not full and not empty: count is unchanged.
- `tx_data` is the head entry. It is don't-care when `tx_valid`=0.

`irq` is registered: `irq` <= |(INT_STAT & INT_EN[2:0]).

Reset values:
- All outputs 0, except `prdata` (0 because `psel` is low) and `pready` (0).
- CTRL, INT_EN, INT_STAT, RX_CNT, FIFO pointers and count, and `wcnt` are all 0.
- FIFO storage is not reset.
- `preset` asserted during a transfer aborts it. No register is written, and `pready` stays 0 until a new access phase.

## Timing

- Write/read latency from the first access-phase cycle to `pready`=1 is `WAIT_STATES` cycles. `WAIT_STATES`=0 gives a zero-wait transfer.
- A TX_DATA write completing at edge N makes `tx_valid`=1 from edge N. The popped word is consumed at the edge with `tx_ready`=1.
- STATUS reflects a push or pop from the edge after it.
- `rx_event` at edge N is visible in RX_CNT from edge N.
- INT_STAT sets at the event edge; `irq` follows one cycle later.

## Test plan

- Reset check: assert `preset` for 2 cycles, then read every register with `WAIT_STATES`=1. Expected: all reads return 0, except STATUS = 0x40. `pready` goes high exactly 1 cycle into each access phase.
- FIFO fill: hold `tx_ready`=0 and write TX_DATA 0xA0..0xA4, five times. Expected:
  - STATUS = 0x24.
  - INT_STAT[2] = 1 after the 5th write.
  - Then hold `tx_ready`=1: `tx_data` outputs 0xA0..0xA3 in order.
  - INT_STAT[0] sets and `tx_valid` drops after the 4th pop.
- Full push plus simultaneous pop: with the FIFO full, complete a TX_DATA write in the same cycle as a pop. Expected: the push is dropped, count = 3, INT_STAT[2] = 1.
- RX counter: preload 0xFFFF `rx_event` pulses, then send 1 more. Expected: RX_CNT = 0 and INT_STAT[1] = 1. With INT_EN = 0x2, `irq` = 1 one cycle later. Writing INT_STAT = 0x2 clears both.
- Clear-on-read collision: with RX_CNT = 5, read RX_CNT with `rx_event` in the completion cycle. Expected: the read returns 5 and RX_CNT = 1 afterwards.
- Wait states and reset mid-transfer: with `WAIT_STATES`=3, expect `pready` low for 3 access cycles and then high. Asserting `preset` in the 2nd access cycle of a CTRL write of 1 leaves `mac_en` = 0.
